// File: rtl/msk_and_sched_if.sv
// Bundle of requester, randomness, gadget and response signals around msk_and_sched.
// slave = scheduler side, master = environment side (requesters, PRNG, gadget, consumer).
interface msk_and_sched_if #(
  parameter int d    = 2,
  parameter int NREQ = 4
);
  localparam int IDW   = $clog2(NREQ);
  localparam int n_rnd = d * (d - 1) / 2;

  // requester i's sharing occupies bits [i*d +: d] of the flattened vector
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][d-1:0]  req_a;
  logic [NREQ-1:0][d-1:0]  req_b;

  logic                    rnd_valid;
  logic                    rnd_ready;
  logic [n_rnd-1:0]        rnd_in;

  logic [d-1:0]            and_ina;
  logic [d-1:0]            and_inb;
  logic [n_rnd-1:0]        and_rnd;
  logic [d-1:0]            and_out;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [d-1:0]            rsp_data;

  modport slave (
    input  req_valid, req_a, req_b, rnd_valid, rnd_in, and_out, rsp_ready,
    output req_ready, rnd_ready, and_ina, and_inb, and_rnd, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, rnd_valid, rnd_in, and_out, rsp_ready,
    input  req_ready, rnd_ready, and_ina, and_inb, and_rnd, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/msk_and_sched.sv
// Round-robin scheduler sharing one 1-cycle masked AND gadget among NREQ requesters.
// Define MSKAND_SCHED_IDLE_ZERO_EN to force gadget inputs to zero in non-issue cycles.

module msk_and_sched_lane #(
  parameter int d = 2
) (
  input  logic         sel,
  input  logic [d-1:0] a,
  input  logic [d-1:0] b,
  output logic [d-1:0] ga,
  output logic [d-1:0] gb
);
  assign ga = a & {d{sel}};
  assign gb = b & {d{sel}};
endmodule

module msk_and_sched #(
  parameter int d    = 2,
  parameter int NREQ = 4
) (
  input logic              clk,
  input logic              rst,
  msk_and_sched_if.slave   bus
);
  localparam int IDW   = $clog2(NREQ);
  localparam int n_rnd = d * (d - 1) / 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [d-1:0]   data;
  } rsp_t;

  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         g;
  logic                   any_req;
  logic [NREQ-1:0]        gnt_oh;
  logic [NREQ-1:0]        sel_oh;
  logic                   inflight;
  logic [IDW-1:0]         inflight_id;
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             fifo_count;
  rsp_t                   mem [2];
  logic                   pop, space, issue;
  logic [2:0]             occ;
  logic [NREQ-1:0][d-1:0] ga, gb;
  logic [d-1:0]           ina, inb;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == IDW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // scan rr_ptr, rr_ptr+1, ... and take the first valid requester
  always_comb begin
    logic [IDW-1:0] idx;
    g       = rr_ptr;
    any_req = 1'b0;
    idx     = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && bus.req_valid[idx]) begin
        g       = idx;
        any_req = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  end

  always_comb begin
    gnt_oh    = '0;
    gnt_oh[g] = 1'b1;
  end

  assign pop   = bus.rsp_valid & bus.rsp_ready;
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign space = (occ < 3'd2);
  assign issue = any_req & bus.rnd_valid & space & ~rst;

  assign bus.req_ready = issue ? gnt_oh : '0;
  assign bus.rnd_ready = issue;

`ifdef MSKAND_SCHED_IDLE_ZERO_EN
  assign sel_oh      = issue ? gnt_oh : '0;
  assign bus.and_rnd = issue ? bus.rnd_in : '0;
`else
  // idle cycles keep presenting the scan's selection; the gadget result is dropped
  assign sel_oh      = gnt_oh;
  assign bus.and_rnd = bus.rnd_in;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    msk_and_sched_lane #(.d(d)) u_lane (
      .sel (sel_oh[i]),
      .a   (bus.req_a[i]),
      .b   (bus.req_b[i]),
      .ga  (ga[i]),
      .gb  (gb[i])
    );
  end

  always_comb begin
    ina = '0;
    inb = '0;
    for (int i = 0; i < NREQ; i++) begin
      ina = ina | ga[i];
      inb = inb | gb[i];
    end
  end

  assign bus.and_ina = ina;
  assign bus.and_inb = inb;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= '0;
      mem[0]      <= '0;
      mem[1]      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rr_ptr      <= wrap_inc(g);
        inflight_id <= g;
      end
      // gadget output is valid exactly one cycle after issue
      if (inflight) begin
        mem[wr_ptr] <= '{id: inflight_id, data: bus.and_out};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign bus.rsp_valid = (fifo_count != 2'd0);
  assign bus.rsp_id    = mem[rd_ptr].id;
  assign bus.rsp_data  = mem[rd_ptr].data;

endmodule

// File: tb/tb_msk_and_sched.sv
// Scoreboard bench for msk_and_sched: a driver predicts grants from a queue-based
// model of outstanding operations, a separate monitor checks responses in order.
module tb_msk_and_sched;
  localparam int d     = 2;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);
  localparam int N_RND = d * (d - 1) / 2;

  typedef struct {
    int             cyc;
    logic [IDW-1:0] id;
    logic [d-1:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msk_and_sched_if #(.d(d), .NREQ(NREQ)) bus ();
  msk_and_sched #(.d(d), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t exp_q[$];
  int   cyc    = 0;
  int   rr_m   = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  // Gadget stand-in: deterministic sharing whose XOR is (^a)&(^b), mixed with all inputs.
  function automatic logic [d-1:0] gadget_f(input logic [d-1:0] a, input logic [d-1:0] b,
                                            input logic [N_RND-1:0] r);
    logic [d-1:0] m;
    logic         p;
    m = a ^ {b[0], b[d-1:1]} ^ {d{^r}};
    p = (^a) & (^b);
    return {m[d-1:1], p ^ (^m[d-1:1])};
  endfunction

  initial bus.and_out = '0;
  always @(posedge clk) bus.and_out <= gadget_f(bus.and_ina, bus.and_inb, bus.and_rnd);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] rv, input logic rndv, input logic rspr,
                       input logic do_rst);
    bit   pop_m, space_m, iss;
    int   g;
    logic [IDW-1:0]  gi;
    logic [NREQ-1:0] exp_rr;
    @(negedge clk);
    cyc++;
    rst           = do_rst;
    bus.req_valid = rv;
    bus.rnd_valid = rndv;
    bus.rsp_ready = rspr;
    bus.req_a     = (NREQ*d)'($urandom);
    bus.req_b     = (NREQ*d)'($urandom);
    bus.rnd_in    = N_RND'($urandom);
    #1;
    if (do_rst) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rnd_ready", 32'(bus.rnd_ready), 32'd0);
      exp_q.delete();
      rr_m = 0;
      return;
    end
    // outstanding ops = issued but not yet consumed; at most two may exist
    pop_m   = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc) && rspr;
    space_m = (exp_q.size() - int'(pop_m)) < 2;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr_m + k) % NREQ;
      if (g < 0 && ((rv >> idx) & 1) != 0) g = idx;
    end
    iss    = (g >= 0) && rndv && space_m;
    gi     = IDW'((g < 0) ? 0 : g);
    exp_rr = iss ? NREQ'(1 << g) : '0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rr));
    chk("rnd_ready", 32'(bus.rnd_ready), 32'(iss));
    if (iss) begin
      chk("and_ina", 32'(bus.and_ina), 32'(bus.req_a[gi]));
      chk("and_inb", 32'(bus.and_inb), 32'(bus.req_b[gi]));
      chk("and_rnd", 32'(bus.and_rnd), 32'(bus.rnd_in));
      exp_q.push_back('{cyc: cyc, id: gi,
                        data: gadget_f(bus.req_a[gi], bus.req_b[gi], bus.rnd_in)});
      rr_m = (g + 1) % NREQ;
    end else begin
`ifdef MSKAND_SCHED_IDLE_ZERO_EN
      chk("idle_ina", 32'(bus.and_ina), 32'd0);
      chk("idle_inb", 32'(bus.and_inb), 32'd0);
      chk("idle_rnd", 32'(bus.and_rnd), 32'd0);
`endif
    end
  endtask

  // Monitor: results must appear in issue order from two cycles after issue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      begin
        bit ev;
        ev = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        if (ev) begin
          chk("rsp_id", 32'(bus.rsp_id), 32'(exp_q[0].id));
          chk("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.rnd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rnd_in    = '0;
    cycle('0, 1'b0, 1'b1, 1'b1);
    cycle('0, 1'b0, 1'b1, 1'b1);
    cycle('0, 1'b0, 1'b1, 1'b0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);

    // lone request from requester 2
    cycle(4'b0100, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle('0, 1'b0, 1'b1, 1'b0);

    // all requesters busy, full throughput from a fresh pointer
    cycle('0, 1'b0, 1'b1, 1'b1);
    repeat (8) cycle(4'hF, 1'b1, 1'b1, 1'b0);

    // starved of randomness, then supplied
    repeat (5) cycle(4'hF, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(4'hF, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle('0, 1'b0, 1'b1, 1'b0);

    // consumer stalled: only two ops may be outstanding
    repeat (6) cycle(4'hF, 1'b1, 1'b0, 1'b0);
    repeat (8) cycle(4'hF, 1'b1, 1'b1, 1'b0);

    // reset right after an issue drops the in-flight op and the pointer
    cycle(4'hF, 1'b1, 1'b1, 1'b0);
    cycle(4'hF, 1'b1, 1'b1, 1'b1);
    cycle(4'b0110, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle('0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 500; i++)
      cycle(NREQ'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) == 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      cycle('0, 1'b0, 1'b1, 1'b0);
    chk("drain_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
